mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the fetch stage (read-only requester) and the data-memory stage (read/write requester) of the 5-stage pipeline.
- Arbitrates between the two requesters with a bounded-starvation policy and sequences each memory transfer until the memory signals ready.
- Returns read data and a one-cycle acknowledge to the winner, and drives stall signals used by the hazard logic to freeze IF_ID and EX_MEM/MEM_WB.
- Enforces a ready timeout that aborts hung transfers with an error flag.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between the fetch and data pipeline stages.
// Fetch starvation is bounded, and a transfer that never sees mem_ready is aborted with bus_err.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT   = 3,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   output logic        if_stall,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic        dm_stall,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [1:0]  owner,
   output logic        bus_err
);

   localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      XFER_IF = 2'd1,
      XFER_DM = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [1:0]    owner_q, owner_d;
   logic          if_ack_q, if_ack_d;
   logic          dm_ack_q, dm_ack_d;
   logic          bus_err_q, bus_err_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   dm_rdata_q, dm_rdata_d;

   logic if_cand, dm_cand, starve_hit, pick_if, done;

   // A request whose ack is on the bus this cycle is stale: the requester drops it next cycle.
   assign if_cand    = if_req & ~if_ack_q;
   assign dm_cand    = dm_req & ~dm_ack_q;
   assign starve_hit = (STARVE_LIMIT != 0) && (starve_q == STARVE_MAX);
   assign pick_if    = if_cand & (~dm_cand | starve_hit);
   assign done       = mem_ready | (tmo_q == TMO_LAST);

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      owner_d     = owner_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      bus_err_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;

      case (state_q)
         IDLE: begin
            if (if_cand | dm_cand) begin
               mem_en_d = 1'b1;
               tmo_d    = '0;
               if (pick_if) begin
                  state_d    = XFER_IF;
                  owner_d    = 2'b01;
                  mem_we_d   = 1'b0;
                  mem_addr_d = if_addr;
                  starve_d   = '0;
               end else begin
                  state_d     = XFER_DM;
                  owner_d     = 2'b10;
                  mem_we_d    = dm_we;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
                  if (if_cand && (starve_q < STARVE_MAX)) begin
                     starve_d = starve_q + SW'(1);
                  end
               end
            end
         end

         XFER_IF, XFER_DM: begin
            if (done) begin
               state_d  = IDLE;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               owner_d  = 2'b00;
               if (state_q == XFER_IF) begin
                  if_ack_d = 1'b1;
               end else begin
                  dm_ack_d = 1'b1;
               end
               // Ready in the final timeout cycle still wins over the abort.
               if (mem_ready) begin
                  if (state_q == XFER_IF) begin
                     if_rdata_d = mem_rdata;
                  end else if (!mem_we_q) begin
                     dm_rdata_d = mem_rdata;
                  end
               end else begin
                  bus_err_d = 1'b1;
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         default: begin
            state_d  = IDLE;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
            owner_d  = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         tmo_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         owner_q     <= 2'b00;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         bus_err_q   <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         owner_q     <= owner_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         bus_err_q   <= bus_err_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_ack    = if_ack_q;
   assign if_stall  = if_req & ~if_ack_q;
   assign dm_rdata  = dm_rdata_q;
   assign dm_ack    = dm_ack_q;
   assign dm_stall  = dm_req & ~dm_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign owner     = owner_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters, a behavioural memory responder,
// and a rule-level model that predicts grants, ack cycles, read data and bus errors.
module tb_mem_port_arbiter;

   localparam int STARVE_LIMIT   = 3;
   localparam int TIMEOUT_CYCLES = 16;

   logic        clk, rst_n;
   logic        if_req, if_ack, if_stall;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_ack, dm_stall;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_en, mem_we, mem_ready, bus_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  owner;

   int checks = 0;
   int errors = 0;
   int waitOverride = -1;

   logic [31:0] memArr [logic [31:0]];
   logic [31:0] refMem [logic [31:0]];

   typedef struct {
      int          port;
      int          cyc;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t expQ[$];

   mem_port_arbiter #(
      .STARVE_LIMIT  (STARVE_LIMIT),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_ack   (if_ack),
      .if_stall (if_stall),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_rdata (dm_rdata),
      .dm_ack   (dm_ack),
      .dm_stall (dm_stall),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .owner    (owner),
      .bus_err  (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory wait states are encoded in address bits [12:8] unless a directed test overrides them.
   function automatic int waitOf(input logic [31:0] a);
      if (waitOverride >= 0) return waitOverride;
      return int'(a[12:8]);
   endfunction

   function automatic logic [31:0] memInit(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   function automatic logic [31:0] refRead(input logic [31:0] a);
      if (refMem.exists(a)) return refMem[a];
      return memInit(a);
   endfunction

   function automatic logic [4:0] pickWait();
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) return 5'($urandom_range(0, 3));
      if (r < 80) return 5'($urandom_range(4, 8));
      if (r < 88) return 5'd15;
      return 5'($urandom_range(16, 20));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Raises one request at posedge+1, holds it until its ack, drops it one cycle later.
   task automatic applyStimulus(input int port, input logic [31:0] addr, input logic we,
                                input logic [31:0] wdata, output int lat);
      int n;
      if (port == 1) begin
         if_addr = addr;
         if_req  = 1'b1;
      end else begin
         dm_addr  = addr;
         dm_we    = we;
         dm_wdata = wdata;
         dm_req   = 1'b1;
      end
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (((port == 1) ? if_ack : dm_ack) === 1'b1) break;
         if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_wait port=%0d actual no ack after %0d cycles required ack", port, n);
            break;
         end
      end
      lat = n;
      @(posedge clk);
      #1;
      if (port == 1) if_req = 1'b0;
      else dm_req = 1'b0;
   endtask

   // Memory responder: raises mem_ready after the address-encoded wait, noise on mem_ready when idle.
   initial begin
      int xferCyc;
      xferCyc   = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n || !mem_en) begin
            xferCyc   = 0;
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
         end else begin
            if (xferCyc == waitOf(mem_addr)) begin
               mem_ready = 1'b1;
               mem_rdata = memArr.exists(mem_addr) ? memArr[mem_addr] : memInit(mem_addr);
               if (mem_we) memArr[mem_addr] = mem_wdata;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
            end
            xferCyc++;
         end
      end
   end

   // Reference model and monitor: predicts each grant from the arbitration rules and
   // compares acks against the scoreboard queue, plus per-cycle bus and hold checks.
   int          cyc = 0, starve = 0, grantCyc = 0, ackCyc = 0, curPort = 0;
   bit          busy = 0, curWe = 0, curErr = 0;
   logic [31:0] curAddr = '0, curWdata = '0, curRdata = '0, lastIf = '0, lastDm = '0;

   always @(negedge clk) begin
      exp_t e;
      bit   xfer, expIfAck, expDmAck, expErr, cIf, cDm;
      int   winner, w;
      if (!rst_n) begin
         busy   = 0;
         starve = 0;
         lastIf = '0;
         lastDm = '0;
         expQ.delete();
      end else begin
         cyc++;
         xfer     = busy && (cyc > grantCyc) && (cyc < ackCyc);
         expIfAck = busy && (cyc == ackCyc) && (curPort == 1);
         expDmAck = busy && (cyc == ackCyc) && (curPort == 2);
         expErr   = busy && (cyc == ackCyc) && curErr;

         if (if_ack || dm_ack) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_ack actual if_ack=%b dm_ack=%b required none", if_ack, dm_ack);
            end else begin
               e = expQ.pop_front();
               checkOutput("ack_port", {30'd0, dm_ack, if_ack}, e.port);
               checkOutput("ack_cycle", cyc, e.cyc);
               checkOutput("ack_bus_err", bus_err, e.err);
               checkOutput("ack_rdata", (e.port == 1) ? if_rdata : dm_rdata, e.rdata);
            end
         end else if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            e = expQ.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missing_ack port=%0d actual none required at cycle %0d", e.port, e.cyc);
         end

         if (busy && cyc == ackCyc) begin
            if (curPort == 1) lastIf = curRdata;
            else lastDm = curRdata;
            busy = 0;
         end

         checkOutput("mem_en", mem_en, xfer);
         checkOutput("owner", owner, xfer ? curPort : 0);
         checkOutput("mem_we", mem_we, xfer && curWe);
         if (xfer) begin
            checkOutput("mem_addr", mem_addr, curAddr);
            if (curWe) checkOutput("mem_wdata", mem_wdata, curWdata);
         end
         checkOutput("if_stall", if_stall, if_req && !expIfAck);
         checkOutput("dm_stall", dm_stall, dm_req && !expDmAck);
         checkOutput("bus_err", bus_err, expErr);
         checkOutput("if_rdata_hold", if_rdata, lastIf);
         checkOutput("dm_rdata_hold", dm_rdata, lastDm);

         if (!busy) begin
            cIf = if_req && !expIfAck;
            cDm = dm_req && !expDmAck;
            if (cIf || cDm) begin
               if (cIf && cDm) winner = (STARVE_LIMIT > 0 && starve == STARVE_LIMIT) ? 1 : 2;
               else winner = cIf ? 1 : 2;
               if (winner == 1) starve = 0;
               else if (cIf && starve < STARVE_LIMIT) starve++;

               curPort  = winner;
               curAddr  = (winner == 1) ? if_addr : dm_addr;
               curWe    = (winner == 2) && dm_we;
               curWdata = dm_wdata;
               w        = waitOf(curAddr);
               curErr   = (w >= TIMEOUT_CYCLES);
               grantCyc = cyc;
               ackCyc   = curErr ? cyc + TIMEOUT_CYCLES + 1 : cyc + w + 2;
               if (curErr || curWe) curRdata = (winner == 1) ? lastIf : lastDm;
               else curRdata = refRead(curAddr);
               if (curWe && !curErr) refMem[curAddr] = curWdata;
               e.port  = winner;
               e.cyc   = ackCyc;
               e.rdata = curRdata;
               e.err   = curErr;
               expQ.push_back(e);
               busy = 1;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual still running required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios first, then concurrent random traffic, then reset during a transfer.
   initial begin
      int lat, latIf, latDm;
      rst_n = 1'b1; if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_mem_en", mem_en, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
      checkOutput("rst_owner", owner, 0);
      checkOutput("rst_if_ack", if_ack, 0);
      checkOutput("rst_dm_ack", dm_ack, 0);
      checkOutput("rst_bus_err", bus_err, 0);
      checkOutput("rst_if_rdata", if_rdata, 0);
      checkOutput("rst_dm_rdata", dm_rdata, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      memArr[32'h100] = 32'h8C220004;
      refMem[32'h100] = 32'h8C220004;
      waitOverride = 0;
      applyStimulus(1, 32'h100, 1'b0, '0, lat);
      checkOutput("fetch_latency", lat, 3);
      checkOutput("fetch_rdata", if_rdata, 32'h8C220004);

      waitOverride = 2;
      applyStimulus(2, 32'h40, 1'b1, 32'hDEADBEEF, lat);
      checkOutput("write_latency", lat, 5);
      checkOutput("write_dm_rdata", dm_rdata, 0);
      applyStimulus(2, 32'h40, 1'b0, '0, lat);
      checkOutput("readback_rdata", dm_rdata, 32'hDEADBEEF);

      waitOverride = 20;
      applyStimulus(2, 32'h80, 1'b0, '0, lat);
      checkOutput("timeout_latency", lat, 18);
      checkOutput("timeout_dm_rdata", dm_rdata, 32'hDEADBEEF);
      waitOverride = -1;

      fork
         begin
            int latF, k;
            for (int i = 0; i < 100; i++) begin
               applyStimulus(1, {2'b01, 17'($urandom), pickWait(), 6'($urandom), 2'b00}, 1'b0, '0, latF);
               k = $urandom_range(0, 4);
               if (k > 2) repeat (k - 2) begin @(posedge clk); #1; end
            end
         end
         begin
            int latD, k;
            for (int i = 0; i < 100; i++) begin
               applyStimulus(2, {2'b10, 17'd0, pickWait(), 6'($urandom_range(0, 7)), 2'b00},
                             1'($urandom_range(0, 1)), $urandom, latD);
               k = $urandom_range(0, 4);
               if (k > 2) repeat (k - 2) begin @(posedge clk); #1; end
            end
         end
      join

      waitOverride = 20;
      dm_addr = 32'h8000_0200; dm_we = 1'b0; dm_req = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      checkOutput("pre_reset_mem_en", mem_en, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_mem_en", mem_en, 0);
      checkOutput("midrst_owner", owner, 0);
      checkOutput("midrst_dm_ack", dm_ack, 0);
      checkOutput("midrst_if_ack", if_ack, 0);
      checkOutput("midrst_dm_rdata", dm_rdata, 0);
      dm_req = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      waitOverride = 0;
      @(posedge clk); #1;
      fork
         applyStimulus(1, 32'h4000_1000, 1'b0, '0, latIf);
         applyStimulus(2, 32'h8000_0300, 1'b0, '0, latDm);
      join
      checkOutput("post_reset_dm_latency", latDm, 3);
      checkOutput("post_reset_if_latency", latIf, 5);
      waitOverride = -1;

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
